// File: rtl/stepper_cmd_queue.sv
// stepper_cmd_queue: buffers stepper motion commands and releases one at a time, gated on motor_en
// completion plus a settle dwell. Define STEPPER_CMDQ_FLUSH_EN to enable abort/flush via wr_data[31].
module stepper_cmd_queue #(
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 16,
  parameter int DWELL_CYCLES  = 1000000
) (
  input  logic                     CLK100MHZ,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     motor_en,
  output logic [31:0]              data_out,
  output logic                     new_data,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (DWELL_CYCLES > START_TIMEOUT) ? DWELL_CYCLES : START_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  // A zero dwell collapses to a single SETTLE cycle, matching the "no dwell" behaviour.
  localparam logic [TW-1:0] DWELL_LAST = (DWELL_CYCLES == 0) ? '0 : TW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, SETTLE} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [31:0]     data_nx;
  logic            new_data_nx;
  logic            pop, push, abort;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

`ifdef STEPPER_CMDQ_FLUSH_EN
  assign abort = wr_en && wr_data[31];
`else
  assign abort = 1'b0;
`endif

  assign fifo_full   = (count == CW'(DEPTH));
  assign fifo_empty  = (count == '0);
  assign queue_count = count;
  assign busy        = (state != IDLE);
  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign push        = wr_en && !fifo_full && !abort;

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    data_nx     = data_out;
    new_data_nx = 1'b0;
    pop         = 1'b0;
    if (abort) begin
      state_nx    = WAIT_START;
      timer_nx    = '0;
      data_nx     = wr_data;
      new_data_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            data_nx     = mem[rd_ptr];
            new_data_nx = 1'b1;
            pop         = 1'b1;
            timer_nx    = '0;
            state_nx    = WAIT_START;
          end
        end
        WAIT_START: begin
          if (motor_en) begin
            state_nx = WAIT_DONE;
          end else if (timer == START_LAST) begin
            state_nx = SETTLE;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!motor_en) begin
            state_nx = SETTLE;
            timer_nx = '0;
          end
        end
        SETTLE: begin
          if (timer == DWELL_LAST) state_nx = IDLE;
          else                     timer_nx = timer + TW'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      data_out <= data_nx;
      new_data <= new_data_nx;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (wr_en && fifo_full) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_stepper_cmd_queue.sv
// tb_stepper_cmd_queue: self-checking bench; issued commands are checked in order against a scoreboard
// queue, cycle behaviour against a vector table and hand-written sequences.
module tb_stepper_cmd_queue;
  localparam int DEPTH = 8;
  localparam int ST    = 16;
  localparam int D     = 20;

  logic        CLK100MHZ = 1'b0;
  logic        reset, wr_en, motor_en;
  logic [31:0] wr_data;
  logic [31:0] data_out;
  logic        new_data, fifo_full, fifo_empty, busy, overflow;
  logic [3:0]  queue_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];
  logic [31:0] sb_exp;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_data;
    logic        motor_en;
    logic [3:0]  count;
    logic        nd;
    logic        busy;
  } vec_t;
  vec_t vt[6];

  stepper_cmd_queue #(.DEPTH(DEPTH), .START_TIMEOUT(ST), .DWELL_CYCLES(D)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .motor_en(motor_en), .data_out(data_out), .new_data(new_data), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .queue_count(queue_count), .busy(busy), .overflow(overflow)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit will_issue);
    wr_en   = 1'b1;
    wr_data = d;
    if (will_issue) sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!new_data && n < 200) begin tick(); n++; end
    chk("pulse_seen", new_data, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("went_idle", busy, 0);
  endtask

  task automatic move();
    motor_en = 1'b1;
    tick();
    motor_en = 1'b0;
    wait_idle();
  endtask

  task automatic serve(input int k);
    for (int i = 0; i < k; i++) begin
      wait_pulse();
      tick();
      move();
    end
  endtask

  // Every issue pulse must carry the oldest outstanding expected command.
  always @(negedge CLK100MHZ) begin
    if (!reset && new_data) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue_order: unexpected pulse data_out=0x%0h expected none", data_out);
      end else begin
        sb_exp = sb.pop_front();
        chk("issue_order", data_out, sb_exp);
      end
    end
  end

  initial begin
    int n;
    vt[0] = '{1'b1, 32'h101, 1'b0, 4'd1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'h102, 1'b0, 4'd1, 1'b1, 1'b1};
    vt[2] = '{1'b1, 32'h103, 1'b0, 4'd2, 1'b0, 1'b1};
    vt[3] = '{1'b0, 32'h0,   1'b1, 4'd2, 1'b0, 1'b1};
    vt[4] = '{1'b0, 32'h0,   1'b1, 4'd2, 1'b0, 1'b1};
    vt[5] = '{1'b0, 32'h0,   1'b0, 4'd2, 1'b0, 1'b1};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; motor_en = 1'b0;
    tick(); tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // single command: latency and dwell timing
    wr(32'h64, 1);
    chk("t1_count_k", queue_count, 1);
    chk("t1_nd_k", new_data, 0);
    tick();
    chk("t1_nd_k1", new_data, 1);
    chk("t1_data", data_out, 32'h64);
    chk("t1_busy", busy, 1);
    chk("t1_count_k1", queue_count, 0);
    tick();
    chk("t1_nd_k2", new_data, 0);
    motor_en = 1'b1;
    repeat (3) tick();
    motor_en = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy && n < 200);
    chk("t1_dwell_cycles", n, D + 1);

    // back-to-back writes, table driven
    for (int i = 0; i < 6; i++) begin
      wr_en = vt[i].wr_en; wr_data = vt[i].wr_data; motor_en = vt[i].motor_en;
      if (vt[i].wr_en) sb.push_back(vt[i].wr_data);
      tick();
      wr_en = 1'b0;
      chk($sformatf("t2_count_%0d", i), queue_count, vt[i].count);
      chk($sformatf("t2_nd_%0d", i), new_data, vt[i].nd);
      chk($sformatf("t2_busy_%0d", i), busy, vt[i].busy);
    end
    n = 0;
    while (!new_data && n < 200) begin tick(); n++; end
    chk("t2_second_issue_delay", n, D + 1);
    chk("t2_count_after", queue_count, 1);
    tick();
    move();
    serve(1);
    chk("t2_empty", fifo_empty, 1);

    // start timeout: motor never enables
    wr(32'h200, 1);
    wr(32'h201, 1);
    chk("t3_first_pulse", new_data, 1);
    tick();
    n = 1;
    while (!new_data && n < 200) begin tick(); n++; end
    chk("t3_timeout_issue_delay", n, ST + 1 + D);
    tick();
    move();

    // overflow while stalled in WAIT_DONE
    wr(32'h300, 1);
    wait_pulse();
    motor_en = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) wr(32'h300 + i, 1);
    chk("t4_full", fifo_full, 1);
    chk("t4_count8", queue_count, 8);
    chk("t4_ovf_before", overflow, 0);
    wr(32'h309, 0);
    chk("t4_ovf_after", overflow, 1);
    chk("t4_count_drop", queue_count, 8);
    motor_en = 1'b0;
    wait_idle();
    serve(8);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_drained", fifo_empty, 1);

    // reset mid-move with entries queued
    wr(32'h400, 1);
    wait_pulse();
    motor_en = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) wr(32'h400 + i, 0);
    chk("t5_count3", queue_count, 3);
    reset = 1'b1;
    tick();
    chk("t5_data_out", data_out, 0);
    chk("t5_new_data", new_data, 0);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_full", fifo_full, 0);
    chk("t5_count", queue_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_overflow", overflow, 0);
    reset = 1'b0;
    motor_en = 1'b0;
    repeat (5) tick();
    chk("t5_stays_idle", busy, 0);

    // abort word written during WAIT_DONE
    wr(32'h500, 1);
    wait_pulse();
    motor_en = 1'b1;
    tick();
`ifdef STEPPER_CMDQ_FLUSH_EN
    for (int i = 1; i <= 4; i++) wr(32'h500 + i, 0);
    chk("t6_count4", queue_count, 4);
    wr(32'h8000_0010, 1);
    chk("t6_flush_count", queue_count, 0);
    chk("t6_flush_nd", new_data, 1);
    chk("t6_flush_data", data_out, 32'h8000_0010);
    chk("t6_flush_busy", busy, 1);
    chk("t6_flush_ovf", overflow, 0);
    tick();
    motor_en = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("t6_flush_empty", fifo_empty, 1);
`else
    for (int i = 1; i <= 4; i++) wr(32'h500 + i, 1);
    chk("t6_count4", queue_count, 4);
    wr(32'h8000_0010, 1);
    chk("t6_noflush_count", queue_count, 5);
    chk("t6_noflush_nd", new_data, 0);
    motor_en = 1'b0;
    wait_idle();
    serve(5);
    chk("t6_noflush_empty", fifo_empty, 1);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
